// File: rtl/pmem_arbiter_pkg.sv
// pmem_arbiter_pkg: LC-3b word/line types and arbiter state encoding shared by the memory-port arbiter.
package pmem_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
endpackage

// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: icache, dcache and physical-memory buses around the arbiter.
interface pmem_arbiter_if;
  import pmem_arbiter_pkg::*;
  logic     i_read;
  lc3b_word i_addr;
  lc3b_line i_rdata;
  logic     i_resp;
  logic     d_read;
  logic     d_write;
  lc3b_word d_addr;
  lc3b_line d_wdata;
  lc3b_line d_rdata;
  logic     d_resp;
  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_addr;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_resp;
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: single-port physical-memory arbiter; dcache has fixed priority, one transaction in flight.
// Grant is registered; memory responses and data pass straight through to the granted client.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  pmem_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  logic serve_i, serve_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ARB_IDLE;
    else state_q <= state_d;
  // dcache first: the MEM stage sits further down the pipeline and must not starve
  always_comb begin
    state_d = state_q;
    if (state_q == ARB_IDLE)
      state_d = (bus.d_read || bus.d_write) ? ARB_SERVE_D : bus.i_read ? ARB_SERVE_I : ARB_IDLE;
    else if (bus.pmem_resp)
      state_d = ARB_IDLE;
  end
  assign serve_i = state_q == ARB_SERVE_I;
  assign serve_d = state_q == ARB_SERVE_D;
  assign bus.pmem_read  = serve_d ? bus.d_read : serve_i & bus.i_read;
  assign bus.pmem_write = serve_d & bus.d_write;
  assign bus.pmem_addr  = serve_d ? bus.d_addr : serve_i ? bus.i_addr : '0;
  assign bus.pmem_wdata = serve_d ? bus.d_wdata : '0;
  assign bus.d_resp     = serve_d & bus.pmem_resp;
  assign bus.d_rdata    = serve_d ? bus.pmem_rdata : '0;
  assign bus.i_resp     = serve_i & bus.pmem_resp;
  assign bus.i_rdata    = serve_i ? bus.pmem_rdata : '0;
  a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus.d_read && bus.d_write));
  a_idle_resp: assert property (@(posedge clk) disable iff (!rst_n) (state_q == ARB_IDLE) |-> !bus.pmem_resp);
  a_hold_d: assert property (@(posedge clk) disable iff (!rst_n) serve_d |-> (bus.d_read || bus.d_write));
  a_hold_i: assert property (@(posedge clk) disable iff (!rst_n) serve_i |-> bus.i_read);
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed protocol scenarios, then random icache/dcache traffic against a memory-semantics model.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;
  typedef logic [403:0] vec_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  pmem_arbiter_if bus();
  pmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  lc3b_line iq[$];
  lc3b_line dq[$];
  lc3b_line ref_mem[lc3b_word];
  lc3b_line mem[lc3b_word];
  bit model_on = 0;
  bit auto_mem = 0;
  logic m_resp = 0, a_resp = 0;
  lc3b_line m_rdata = '0, a_rdata = '0;
  assign bus.pmem_resp  = auto_mem ? a_resp : m_resp;
  assign bus.pmem_rdata = auto_mem ? a_rdata : m_rdata;

  function automatic lc3b_line init_line(input lc3b_word a);
    return {8{a ^ 16'hA5C3}};
  endfunction

  task automatic chk(input string name, input vec_t a, input vec_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input lc3b_line rd);
    m_resp = 1'b1;
    m_rdata = rd;
    tick();
    m_resp = 1'b0;
    m_rdata = '0;
  endtask

  // Scoreboard pops on every client response; the grant model checks every output each cycle
  int owner = 0, p_owner = 0;
  logic p_resp = 0, p_d = 0, p_i = 0;
  vec_t e_v;
  initial forever begin
    @(negedge clk);
    if (bus.i_resp) begin
      if (iq.size() == 0) chk("i_resp_unexpected", vec_t'(bus.i_resp), '0);
      else chk("i_rdata", vec_t'(bus.i_rdata), vec_t'(iq.pop_front()));
    end
    if (bus.d_resp) begin
      if (dq.size() == 0) chk("d_resp_unexpected", vec_t'(bus.d_resp), '0);
      else chk("d_rdata", vec_t'(bus.d_rdata), vec_t'(dq.pop_front()));
    end
    owner = !model_on ? 0 : p_owner != 0 ? (p_resp ? 0 : p_owner) : p_d ? 2 : p_i ? 1 : 0;
    e_v = owner == 2 ? {bus.d_read, bus.d_write, bus.d_addr, bus.d_wdata, 1'b0, 128'h0, bus.pmem_resp, bus.pmem_rdata}
        : owner == 1 ? {bus.i_read, 1'b0, bus.i_addr, 128'h0, bus.pmem_resp, bus.pmem_rdata, 1'b0, 128'h0}
        : '0;
    if (model_on)
      chk("outputs", {bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.pmem_wdata,
                      bus.i_resp, bus.i_rdata, bus.d_resp, bus.d_rdata}, e_v);
    p_owner = owner;
    p_resp = bus.pmem_resp;
    p_d = bus.d_read | bus.d_write;
    p_i = bus.i_read;
  end

  // Random-latency memory responder holding its own storage
  int wcnt = 0, lat = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (a_resp) begin
        a_resp = 1'b0;
        a_rdata = '0;
        wcnt = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (wcnt >= lat) begin
          a_resp = 1'b1;
          if (bus.pmem_write) mem[bus.pmem_addr] = bus.pmem_wdata;
          else a_rdata = mem.exists(bus.pmem_addr) ? mem[bus.pmem_addr] : init_line(bus.pmem_addr);
          lat = $urandom_range(0, 4);
        end else wcnt++;
      end
    end
  end

  task automatic wait_resp(input bit dside);
    int t;
    logic r;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      r = dside ? bus.d_resp : bus.i_resp;
    end while (!r && t < 100);
    if (!r) chk(dside ? "d_timeout" : "i_timeout", vec_t'(r), vec_t'(1'b1));
    tick();
  endtask

  task automatic i_client(input int n);
    lc3b_word a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 16'($urandom_range(0, 1023)) << 4;
      iq.push_back(init_line(a));
      bus.i_addr = a;
      bus.i_read = 1'b1;
      wait_resp(1'b0);
      bus.i_read = 1'b0;
    end
  endtask

  task automatic d_client(input int n);
    lc3b_word a;
    lc3b_line w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 16'h8000 | (16'($urandom_range(0, 15)) << 4);
      bus.d_addr = a;
      if ($urandom_range(0, 1) == 1) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        ref_mem[a] = w;
        dq.push_back('0);
        bus.d_wdata = w;
        bus.d_write = 1'b1;
      end else begin
        dq.push_back(ref_mem.exists(a) ? ref_mem[a] : init_line(a));
        bus.d_read = 1'b1;
      end
      wait_resp(1'b1);
      bus.d_read = 1'b0;
      bus.d_write = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) tick();
    chk("rst_outputs", vec_t'({bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.pmem_wdata, bus.i_resp, bus.d_resp}), '0);
    rst_n = 1;
    tick();
    // reset while the icache is being served
    bus.i_addr = 16'h1230; bus.i_read = 1;
    tick();
    chk("t1_strobe", vec_t'(bus.pmem_read), vec_t'(1'b1));
    #2 rst_n = 0;
    #1;
    chk("t1_drop", vec_t'(bus.pmem_read), '0);
    chk("t1_state", vec_t'(dut.state_q), vec_t'(ARB_IDLE));
    chk("t1_no_iresp", vec_t'(bus.i_resp), '0);
    bus.i_read = 0;
    #3 rst_n = 1;
    repeat (2) tick();
    chk("t1_idle", vec_t'(bus.pmem_read), '0);
    model_on = 1;
    // icache fill alone
    bus.i_addr = 16'h0040; bus.i_read = 1;
    iq.push_back(128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    tick();
    chk("t2_strobe", vec_t'({bus.pmem_read, bus.pmem_addr}), vec_t'({1'b1, 16'h0040}));
    repeat (4) tick();
    m_resp = 1; m_rdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    #1;
    chk("t2_iresp", vec_t'({bus.i_resp, bus.i_rdata, bus.d_resp}), vec_t'({1'b1, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 1'b0}));
    tick();
    m_resp = 0; m_rdata = '0; bus.i_read = 0;
    chk("t2_idle", vec_t'(bus.pmem_read), '0);
    // dcache writeback
    bus.d_addr = 16'h8000; bus.d_wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF; bus.d_write = 1;
    dq.push_back('0);
    tick();
    chk("t3_wr", vec_t'({bus.pmem_write, bus.pmem_read, bus.pmem_addr, bus.pmem_wdata}),
        vec_t'({1'b1, 1'b0, 16'h8000, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF}));
    tick();
    respond('0);
    bus.d_write = 0;
    // simultaneous requests: dcache first, icache after one bubble
    bus.i_addr = 16'h0100; bus.i_read = 1; bus.d_addr = 16'h4000; bus.d_read = 1;
    dq.push_back({4{32'h4000_D00D}});
    iq.push_back({4{32'h0100_1CE1}});
    tick();
    chk("t4_dfirst", vec_t'({bus.pmem_read, bus.pmem_addr}), vec_t'({1'b1, 16'h4000}));
    respond({4{32'h4000_D00D}});
    bus.d_read = 0;
    chk("t4_bubble", vec_t'(bus.pmem_read), '0);
    tick();
    chk("t4_ithen", vec_t'({bus.pmem_read, bus.pmem_addr}), vec_t'({1'b1, 16'h0100}));
    respond({4{32'h0100_1CE1}});
    bus.i_read = 0;
    // dcache arriving mid-icache is not preempted
    bus.i_addr = 16'h0200; bus.i_read = 1;
    iq.push_back({4{32'h0200_AAAA}});
    repeat (2) tick();
    bus.d_addr = 16'h4010; bus.d_read = 1;
    dq.push_back({4{32'h4010_BBBB}});
    tick();
    chk("t5_nopreempt", vec_t'({bus.pmem_read, bus.pmem_addr}), vec_t'({1'b1, 16'h0200}));
    respond({4{32'h0200_AAAA}});
    bus.i_read = 0;
    chk("t5_bubble", vec_t'(bus.pmem_read), '0);
    tick();
    chk("t5_dgrant", vec_t'({bus.pmem_read, bus.pmem_addr}), vec_t'({1'b1, 16'h4010}));
    respond({4{32'h4010_BBBB}});
    bus.d_read = 0;
    // back-to-back dcache writeback then fill
    bus.d_addr = 16'h8000; bus.d_wdata = {4{32'h6666_7777}}; bus.d_write = 1;
    dq.push_back('0);
    tick();
    respond('0);
    bus.d_write = 0; bus.d_wdata = '0; bus.d_addr = 16'h4000; bus.d_read = 1;
    dq.push_back({4{32'h4000_F111}});
    chk("t6_gap", vec_t'({bus.pmem_read, bus.pmem_write, bus.pmem_addr}), '0);
    tick();
    chk("t6_fill", vec_t'({bus.pmem_read, bus.pmem_write, bus.pmem_addr}), vec_t'({1'b1, 1'b0, 16'h4000}));
    respond({4{32'h4000_F111}});
    bus.d_read = 0;
    tick();
    // random contention
    auto_mem = 1;
    fork
      i_client(40);
      d_client(40);
    join
    repeat (5) tick();
    chk("iq_drained", vec_t'(iq.size()), '0);
    chk("dq_drained", vec_t'(dq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
